// File: rtl/proc_control.sv
// rtl/proc_control.sv - control FSM of the 9-bit simple processor; PROC_CTRL_ILLEGAL_EN adds err output
module proc_control #(
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] DIN,
  output logic [7:0]        Rout,
  output logic              DINout,
  output logic              Gout,
  output logic [7:0]        Rin,
  output logic              Ain,
  output logic              Gin,
  output logic              AddSub,
  output logic              done
`ifdef PROC_CTRL_ILLEGAL_EN
  , output logic            err
`endif
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_ir;

  logic [2:0] w_op;
  logic [2:0] w_x;
  logic [2:0] w_y;
  logic       w_arith;

  assign w_op    = r_ir[DATA_W-1 -: 3];
  assign w_x     = r_ir[DATA_W-4 -: 3];
  assign w_y     = r_ir[DATA_W-7 -: 3];
  assign w_arith = (w_op[2:1] == 2'b01);

  // T2/T3 holding a non-arithmetic opcode can only come from corruption; fall back to T0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= T0;
      r_ir    <= '0;
    end else begin
      case (r_state)
        T0: begin
          if (run) begin
            r_ir    <= DIN;
            r_state <= T1;
          end
        end
        T1:      r_state <= w_arith ? T2 : T0;
        T2:      r_state <= w_arith ? T3 : T0;
        T3:      r_state <= T0;
        default: r_state <= T0;
      endcase
    end
  end

  always_comb begin
    Rout   = '0;
    DINout = 1'b0;
    Gout   = 1'b0;
    Rin    = '0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    AddSub = 1'b0;
    done   = 1'b0;
`ifdef PROC_CTRL_ILLEGAL_EN
    err    = 1'b0;
`endif
    case (r_state)
      T1: begin
        case (w_op)
          3'b000: begin
            Rout = 8'b1 << w_y;
            Rin  = 8'b1 << w_x;
            done = 1'b1;
          end
          3'b001: begin
            DINout = 1'b1;
            Rin    = 8'b1 << w_x;
            done   = 1'b1;
          end
          3'b010, 3'b011: begin
            Rout = 8'b1 << w_x;
            Ain  = 1'b1;
          end
          default: begin
            done = 1'b1;
`ifdef PROC_CTRL_ILLEGAL_EN
            err  = 1'b1;
`endif
          end
        endcase
      end
      T2: begin
        if (w_arith) begin
          Rout   = 8'b1 << w_y;
          Gin    = 1'b1;
          AddSub = w_op[0];
        end
      end
      T3: begin
        if (w_arith) begin
          Gout = 1'b1;
          Rin  = 8'b1 << w_x;
          done = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_proc_control.sv
// tb/tb_proc_control.sv - scoreboard bench for proc_control against an instruction-level model
module tb_proc_control;

  logic       clk = 1'b0;
  logic       resetn;
  logic       run;
  logic [8:0] DIN;
  logic [7:0] Rout;
  logic       DINout, Gout;
  logic [7:0] Rin;
  logic       Ain, Gin, AddSub, done;
  logic       dut_err;

`ifdef PROC_CTRL_ILLEGAL_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
  assign dut_err = 1'b0;
`endif

  proc_control #(.DATA_W(9)) dut (
    .clk(clk), .resetn(resetn), .run(run), .DIN(DIN),
    .Rout(Rout), .DINout(DINout), .Gout(Gout), .Rin(Rin),
    .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .done(done)
`ifdef PROC_CTRL_ILLEGAL_EN
    , .err(dut_err)
`endif
  );

  always #5 clk = ~clk;

  typedef logic [22:0] vec_t;

  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  function automatic vec_t mk(input logic [7:0] rout, input logic dinout, input logic gout,
                              input logic [7:0] rin, input logic ain, input logic gin,
                              input logic addsub, input logic dn, input logic er);
    return {rout, dinout, gout, rin, ain, gin, addsub, dn, er};
  endfunction

  function automatic vec_t actual();
    return {Rout, DINout, Gout, Rin, Ain, Gin, AddSub, done, dut_err};
  endfunction

  // Cycles after the run cycle that an instruction occupies.
  function automatic int n_steps(input logic [8:0] ins);
    return (ins[8:6] == 3'd2 || ins[8:6] == 3'd3) ? 3 : 1;
  endfunction

  // Bus and load activity of step k (1-based) of an instruction, from the ISA description.
  function automatic vec_t step_out(input logic [8:0] ins, input int k);
    logic [7:0] sx, sy;
    sx = 8'd1 << ins[5:3];
    sy = 8'd1 << ins[2:0];
    case (ins[8:6])
      3'd0: return mk(sy, 0, 0, sx, 0, 0, 0, 1, 0);
      3'd1: return mk(0, 1, 0, sx, 0, 0, 0, 1, 0);
      3'd2, 3'd3: begin
        if (k == 1) return mk(sx, 0, 0, 0, 1, 0, 0, 0, 0);
        if (k == 2) return mk(sy, 0, 0, 0, 0, 1, ins[6], 0, 0);
        return mk(0, 0, 1, sx, 0, 0, 0, 1, 0);
      end
      default: return mk(0, 0, 0, 0, 0, 0, 0, 1, ILL);
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow act=%h required=queued entry", actual());
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        if (actual() !== e) begin
          errors++;
          $display("FAIL cycle_outputs t=%0t act=%h required=%h", $time, actual(), e);
        end
      end
      checks++;
      if ($countones({Rout, DINout, Gout}) > 1) begin
        errors++;
        $display("FAIL bus_onehot t=%0t act=%b required=at most one", $time, {Rout, DINout, Gout});
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    run = 1'b0;
    DIN = 9'($urandom);
    exp_q.push_back('0);
  endtask

  task automatic issue(input logic [8:0] ins);
    @(posedge clk); #1;
    run = 1'b1;
    DIN = ins;
    exp_q.push_back('0);
    for (int k = 1; k <= n_steps(ins); k++) begin
      @(posedge clk); #1;
      run = 1'($urandom_range(0, 1));
      DIN = 9'($urandom);
      exp_q.push_back(step_out(ins, k));
    end
  endtask

  task automatic direct_check(input string name);
    checks++;
    if (actual() !== '0) begin
      errors++;
      $display("FAIL %s act=%h required=0", name, actual());
    end
  endtask

  initial begin
    resetn = 1'b0;
    run    = 1'b0;
    DIN    = '0;
    repeat (3) @(posedge clk);
    #1 direct_check("reset_state");

    @(posedge clk); #1;
    resetn = 1'b1;
    exp_q.push_back('0);
    mon_en = 1'b1;

    issue(9'b001_101_000);
    issue(9'b000_010_110);
    issue(9'b011_001_011);
    issue(9'b010_100_100);
    issue(9'b010_000_111);
    issue(9'b000_011_011);
    issue(9'b101_000_000);
    idle();

    // Asynchronous reset landing in T2 of an add.
    @(posedge clk); #1;
    run = 1'b1;
    DIN = 9'b010_011_101;
    exp_q.push_back('0);
    @(posedge clk); #1;
    run = 1'b1;
    exp_q.push_back(step_out(9'b010_011_101, 1));
    @(posedge clk); #1;
    exp_q.push_back(step_out(9'b010_011_101, 2));
    @(negedge clk); #1;
    mon_en = 1'b0;
    resetn = 1'b0;
    #1 direct_check("reset_async_mid_add");
    @(posedge clk); #1;
    direct_check("reset_held_no_rin");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_before_reset_exit act=%0d required=0", exp_q.size());
    end
    exp_q.delete();
    resetn = 1'b0;
    run = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    exp_q.push_back('0);
    mon_en = 1'b1;

    for (int i = 0; i < 60; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle();
      issue(9'($urandom));
    end
    idle();
    @(negedge clk); #1;
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain act=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
